// File: rtl/mem_fifo_ctrl_if.sv
// mem_fifo_ctrl_if: stream and RAM-port bundle for mem_fifo_ctrl.
// The slave modport is the controller's view. The master modport is the
// surrounding producer/consumer/RAM view.
interface mem_fifo_ctrl_if #(
    parameter int XLEN = 32,
    parameter int SIZE = 256
);
    localparam int ADDR = $clog2(SIZE);

    // producer side
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_data;

    // consumer side
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_data;

    // simple dual-port RAM side
    logic [ADDR-1:0] mem_write_addr;
    logic [XLEN-1:0] mem_write_data;
    logic [ADDR-1:0] mem_read_addr;
    logic [XLEN-1:0] mem_read_data;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        input  out_ready,
        output mem_write_addr,
        output mem_write_data,
        output mem_read_addr,
        input  mem_read_data
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        output out_ready,
        input  mem_write_addr,
        input  mem_write_data,
        input  mem_read_addr,
        output mem_read_data
    );
endinterface

// File: rtl/mem_fifo_ctrl.sv
// mem_fifo_ctrl: FIFO controller wrapped around a simple dual-port RAM that
// writes on every edge and returns read data one cycle after the address.
// The controller owns both pointers, RAM occupancy, the read-return credit and
// a 3-entry output buffer that absorbs the RAM read latency.
// Optional feature: define MEM_FIFO_LEVEL_EN to add the registered 'level'
// output (total words held: RAM + in flight + output buffer).
module mem_fifo_ctrl #(
    parameter int XLEN = 32,
    parameter int SIZE = 256
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef MEM_FIFO_LEVEL_EN
    output logic [$clog2(SIZE):0]  level,
`endif
    mem_fifo_ctrl_if.slave         bus
);
    localparam int ADDR = $clog2(SIZE);
    localparam int LW   = ADDR + 1;
    // The slot at wr_ptr is overwritten every edge, so one slot stays empty.
    localparam logic [ADDR-1:0] RAM_MAX = ADDR'(SIZE - 1);

    // Pointers and occupancy
    logic [ADDR-1:0] wr_ptr;
    logic [ADDR-1:0] rd_ptr;
    logic [ADDR-1:0] ram_cnt;
    logic [ADDR-1:0] ram_cnt_nxt;

    // Read-return credit and output buffer bookkeeping
    logic [1:0]      inflight;
    logic [1:0]      inflight_nxt;
    logic [1:0]      obuf_cnt;
    logic [1:0]      obuf_cnt_nxt;
    logic [1:0]      obuf_head;
    logic [1:0]      obuf_tail;
    logic [XLEN-1:0] obuf [3];

    // vld_p1: a read issued last cycle has its data on mem_read_data now
    logic            vld_p1;
    logic            in_ready_q;

    logic            push;
    logic            pop;
    logic            issue;
    logic            cap;

    // Advance a 0..2 ring index.
    function automatic logic [1:0] inc3(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Credit check: buffered + returning words must leave room for one more.
    function automatic logic has_credit(input logic [1:0] ob, input logic [1:0] fl);
        return ({1'b0, ob} + {1'b0, fl}) < 3'd3;
    endfunction

    // Handshakes, read issue and next-state counter arithmetic.
    always_comb begin
        push         = bus.in_valid && in_ready_q;
        pop          = (obuf_cnt != 2'd0) && bus.out_ready;
        issue        = (ram_cnt != '0) && has_credit(obuf_cnt, inflight);
        cap          = vld_p1;

        ram_cnt_nxt  = ram_cnt;
        unique case ({push, issue})
            2'b10:   ram_cnt_nxt = ram_cnt + ADDR'(1);
            2'b01:   ram_cnt_nxt = ram_cnt - ADDR'(1);
            default: ram_cnt_nxt = ram_cnt;
        endcase

        inflight_nxt = inflight + 2'(issue) - 2'(cap);
        obuf_cnt_nxt = obuf_cnt + 2'(cap) - 2'(pop);
    end

    // RAM port and stream outputs; all handshake outputs come from registers.
    assign bus.mem_write_addr = wr_ptr;
    assign bus.mem_write_data = bus.in_data;
    assign bus.mem_read_addr  = rd_ptr;
    assign bus.in_ready       = in_ready_q;
    assign bus.out_valid      = (obuf_cnt != 2'd0);
    assign bus.out_data       = obuf[obuf_head];

    // Control state: pointers, counters, return pipeline valid, ready flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ram_cnt    <= '0;
            inflight   <= 2'd0;
            obuf_cnt   <= 2'd0;
            obuf_head  <= 2'd0;
            obuf_tail  <= 2'd0;
            vld_p1     <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + ADDR'(1);
            end
            if (cap) begin
                obuf_tail <= inc3(obuf_tail);
            end
            if (pop) begin
                obuf_head <= inc3(obuf_head);
            end
            ram_cnt    <= ram_cnt_nxt;
            inflight   <= inflight_nxt;
            obuf_cnt   <= obuf_cnt_nxt;
            vld_p1     <= issue;
            in_ready_q <= (ram_cnt_nxt != RAM_MAX);
        end
    end

    // Output buffer storage: capture the RAM word returning this cycle.
    always_ff @(posedge clk) begin
        if (cap) begin
            obuf[obuf_tail] <= bus.mem_read_data;
        end
    end

`ifdef MEM_FIFO_LEVEL_EN
    // Total occupancy, tracking the counters on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= '0;
        end else begin
            level <= LW'(ram_cnt_nxt) + LW'(inflight_nxt) + LW'(obuf_cnt_nxt);
        end
    end
`endif

    // The credit rule must keep the output buffer from overflowing.
    obuf_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(cap && !pop && (obuf_cnt == 2'd3)));

    // RAM occupancy never exceeds SIZE-1 nor drops below zero.
    ram_cnt_bounds: assert property (@(posedge clk) disable iff (rst)
        !(push && !issue && (ram_cnt == RAM_MAX)) && !(issue && (ram_cnt == '0)));

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// tb_mem_fifo_ctrl: self-checking bench for mem_fifo_ctrl with a behavioural
// model of the attached simple dual-port RAM and a queue scoreboard.
module tb_mem_fifo_ctrl;
    localparam int XLEN = 32;
    localparam int SIZE = 256;
    localparam int FULL = SIZE + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_fifo_ctrl_if #(.XLEN(XLEN), .SIZE(SIZE)) bus ();

`ifdef MEM_FIFO_LEVEL_EN
    logic [$clog2(SIZE):0] level;
`endif

    mem_fifo_ctrl #(.XLEN(XLEN), .SIZE(SIZE)) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef MEM_FIFO_LEVEL_EN
        .level (level),
`endif
        .bus   (bus)
    );

    // RAM model: unconditional write, registered read, old data on collision
    logic [XLEN-1:0] ram [SIZE];
    always_ff @(posedge clk) begin
        ram[bus.mem_write_addr] <= bus.mem_write_data;
        bus.mem_read_data       <= ram[bus.mem_read_addr];
    end

    int checks = 0;
    int errors = 0;
    int npush  = 0;
    int npop   = 0;
    logic [XLEN-1:0] sb [$];

    typedef struct {
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        irdy;
        logic        ovld;
        int          lvl;
    } vec_t;
    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_level(input string name, input int exp);
`ifdef MEM_FIFO_LEVEL_EN
        chk(name, 32'(level), 32'(exp));
`else
        if (exp < 0) $display("negative level request for %s", name);
`endif
    endtask

    // Drive inputs for the coming edge and account for the push/pop it makes.
    task automatic drive(input logic iv, input logic [XLEN-1:0] id, input logic ordy);
        logic [XLEN-1:0] exp;
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.out_ready = ordy;
        #1;
        if (sb.size() == FULL) chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        if (bus.out_valid && bus.out_ready) begin
            npop++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_when_empty: got out_valid=1 data 0x%0h, expected no word held", bus.out_data);
            end else begin
                exp = sb.pop_front();
                chk("pop_data", bus.out_data, exp);
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            sb.push_back(bus.in_data);
            npush++;
        end
    endtask

    task automatic cycle(input logic iv, input logic [XLEN-1:0] id, input logic ordy);
        @(negedge clk);
        drive(iv, id, ordy);
    endtask

    // Pop everything within a bound, then confirm the FIFO is empty.
    task automatic drain(input string name, input int bound, input int exp_pops);
        npop = 0;
        for (int i = 0; i < bound && sb.size() != 0; i++) cycle(1'b0, '0, 1'b1);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({name, "_left"}, 32'(sb.size()), 32'd0);
        chk({name, "_pops"}, 32'(npop), 32'(exp_pops));
        chk({name, "_ovld"}, 32'(bus.out_valid), 32'd0);
        chk_level({name, "_level"}, 0);
    endtask

    // Push with out_ready low until full, bounded.
    task automatic fill(input logic [XLEN-1:0] base);
        npush = 0;
        for (int i = 0; i < 300; i++) cycle(1'b1, base + 32'(npush), 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("fill_count", 32'(npush), 32'(FULL));
        chk("fill_in_ready", 32'(bus.in_ready), 32'd0);
        chk("fill_out_valid", 32'(bus.out_valid), 32'd1);
        chk_level("fill_level", FULL);
    endtask

    initial begin
        int gaps;
        int held;

        //                 iv    data           ordy  irdy  ovld  lvl
        vecs[0] = '{1'b1, 32'hA5A5_0001, 1'b0, 1'b1, 1'b0, 0};
        vecs[1] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1};
        vecs[2] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1};
        vecs[3] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1};
        vecs[4] = '{1'b1, 32'hB000_0001, 1'b1, 1'b1, 1'b0, 0};
        vecs[5] = '{1'b1, 32'hB000_0002, 1'b1, 1'b1, 1'b0, 1};
        vecs[6] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 2};
        vecs[7] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 2};
        vecs[8] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1};
        vecs[9] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 0};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk_level("rst_level", 0);
        rst = 1'b0;
        @(posedge clk);

        // single word latency and two back-to-back words
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'(vecs[i].irdy));
            chk($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].ovld));
            chk_level($sformatf("vec%0d_level", i), vecs[i].lvl);
            drive(vecs[i].iv, vecs[i].id, vecs[i].ordy);
        end
        chk("vec_left", 32'(sb.size()), 32'd0);

        // fill with out_ready low, then drain in order 0..257
        fill(32'h0);
        drain("fill_drain", 400, FULL);

        // streaming: one word per cycle both ways after the fill latency
        npush = 0;
        npop  = 0;
        gaps  = 0;
        for (int i = 0; i < 1000; i++) begin
            cycle(1'b1, 32'h1000_0000 + 32'(i), 1'b1);
            if (i >= 3 && !bus.out_valid) gaps++;
        end
        chk("stream_pushes", 32'(npush), 32'd1000);
        chk("stream_pops", 32'(npop), 32'd997);
        chk("stream_gaps", 32'(gaps), 32'd0);
        drain("stream_drain", 20, 3);

        // random valid/ready at 50%
        for (int i = 0; i < 10000; i++) begin
            cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
        end
        held = sb.size();
        drain("rand_drain", 400, held);

        // wrap-around: full RAM, then concurrent push and pop
        fill(32'hC000_0000);
        for (int i = 0; i < 600; i++) cycle(1'b1, 32'hC000_0000 + 32'(npush), 1'b1);
        held = sb.size();
        drain("wrap_drain", 400, held);

        // reset mid-stream with words queued and reads in flight
        for (int i = 0; i < 100; i++) cycle(1'b1, 32'hD000_0000 + 32'(i), 1'b0);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        @(posedge clk);
        #2;
        chk("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk_level("post_rst_level", 0);
        npop = 0;
        drive(1'b1, 32'hE000_0001, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("post_rst_pops", 32'(npop), 32'd1);
        chk("post_rst_left", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global bound on simulated time.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", checks, errors);
        $fatal(1, "time limit");
    end

endmodule
